// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  // True when the data byte plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module ps2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_50_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = count_q;
  // Head byte reads as zero while empty so the output is defined out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Storage write port.
  // NOTE: the storage array has no reset; only pointers and count do, so
  // stale words are never visible and the array can map to plain RAM.
  always_ff @(posedge clk_50_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and deglitch the pins, deframe
// 11-bit frames, flag errors and buffer good bytes in a FWFT FIFO.
// Everything runs on clk_50_i; ps2_clk_i is only ever sampled as data.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int FILTER_LEN   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_US   = 2000,
  parameter int CHECK_PARITY = 1
) (
  input  logic                            clk_50_i,
  input  logic                            rst_i,
  input  logic                            ps2_clk_i,
  input  logic                            ps2_dat_i,
  output logic [PS2_DATA_BITS-1:0]        data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            parity_err_o,
  output logic                            frame_err_o,
  output logic                            overflow_o
);

  localparam int TO_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);
  localparam int FW        = $clog2(FILTER_LEN);
  localparam logic [FW-1:0]   FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TO_CYCLES);

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          clk_s;
  logic          dat_s;
  logic [FW-1:0] filt_cnt_q;
  logic          clk_filt_q;
  logic          clk_filt_dly_q;
  logic          edge_stb;

  ps2_rx_state_t           state_q,   state_d;
  logic [2:0]              bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q,  shift_d;
  logic                    par_q,     par_d;
  logic [TO_W-1:0]         to_cnt_q,  to_cnt_d;
  logic                    timeout;
  logic                    push_d,    push_q;
  logic [PS2_DATA_BITS-1:0] push_data_q;
  logic                    perr_d,    perr_q;
  logic                    ferr_d,    ferr_q;
  logic                    ovf_q;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  // Two-flop synchronisers; reset to the idle-high bus level.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
  // pre-edge value and the shift chain does not collapse into one flop.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  end

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // Clock deglitch: the filtered clock follows only after FILTER_LEN
  // consecutive samples disagree with it.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      filt_cnt_q     <= '0;
      clk_filt_q     <= 1'b1;
      clk_filt_dly_q <= 1'b1;
    end else begin
      clk_filt_dly_q <= clk_filt_q;
      if (clk_s == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_MAX) begin
        clk_filt_q <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FW'(1);
      end
    end
  end

  // One-cycle strobe on each falling edge of the filtered clock.
  assign edge_stb = clk_filt_dly_q & ~clk_filt_q;
  assign timeout  = (state_q != IDLE) && (to_cnt_q == TO_MAX);

  // Deframer next-state logic; an edge takes priority over a timeout.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    push_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    to_cnt_d  = (state_q == IDLE || edge_stb) ? '0 : to_cnt_q + TO_W'(1);

    if (edge_stb) begin
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, par_q)) begin
            push_d = 1'b1;
          end else begin
            perr_d = 1'b1;
            push_d = (CHECK_PARITY == 0);
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  // Deframer state and registered push / error outputs.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      push_q      <= push_d;
      push_data_q <= shift_q;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign pop = ready_i & valid_o;

  // Overflow: a good byte arrives at a full FIFO that is not being popped.
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= push_q & fifo_full & ~pop;
  end

  ps2_sync_fifo #(
    .WIDTH(PS2_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_50_i (clk_50_i),
    .rst_i    (rst_i),
    .push     (push_q),
    .push_data(push_data_q),
    .pop      (pop),
    .rd_data  (data_o),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (count_o)
  );

  assign valid_o      = ~fifo_empty;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: table of single frames, hand-written
// overflow and reset sequences, then random frames with random pops.
module tb_ps2_rx_fifo;

  localparam int HALF     = 50;   // PS/2 half bit period in system cycles
  localparam int SETTLE   = 300;  // longer than the inter-edge timeout
  localparam int DEPTH    = 8;
  localparam int TO_US    = 5;    // 250 cycles at 50 MHz

  logic       clk_50 = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ready = 1'b0;
  logic       ready_req = 1'b0;
  logic       rand_ready = 1'b0;

  logic [7:0] data;
  logic       valid;
  logic [3:0] count;
  logic       perr, ferr, ovf;
  logic [7:0] np_data;
  logic       np_valid;
  logic [3:0] np_count;
  logic       np_perr, np_ferr, np_ovf;

  always #10 clk_50 = ~clk_50;

  ps2_rx_fifo #(
    .CLK_FREQ_HZ(50_000_000), .FILTER_LEN(8), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_US(TO_US), .CHECK_PARITY(1)
  ) dut (
    .clk_50_i(clk_50), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .data_o(data), .valid_o(valid), .ready_i(ready), .count_o(count),
    .parity_err_o(perr), .frame_err_o(ferr), .overflow_o(ovf)
  );

  // Second instance accepting bad-parity bytes; always drained.
  ps2_rx_fifo #(
    .CLK_FREQ_HZ(50_000_000), .FILTER_LEN(8), .FIFO_DEPTH(DEPTH),
    .TIMEOUT_US(TO_US), .CHECK_PARITY(0)
  ) dut_np (
    .clk_50_i(clk_50), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .data_o(np_data), .valid_o(np_valid), .ready_i(1'b1), .count_o(np_count),
    .parity_err_o(np_perr), .frame_err_o(np_ferr), .overflow_o(np_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected byte streams as write/read indexed arrays.
  logic [7:0] exp_mem [1024];
  logic [7:0] np_mem  [1024];
  int wr_idx = 0, rd_idx = 0;
  int np_wr = 0, np_rd = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;

  // Pulse / event counters maintained by the monitor.
  int perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0, vrise_cnt = 0, pop_cnt = 0;
  int np_perr_cnt = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Single driver of ready_i: random during the stress phase, else requested.
  always @(posedge clk_50) begin
    #2;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
  end

  // Monitor: count pulses, compare every pop against the model stream.
  always @(negedge clk_50) begin
    if (rst) begin
      rd_idx = wr_idx;
      np_rd  = np_wr;
    end else begin
      perr_cnt    += int'(perr);
      ferr_cnt    += int'(ferr);
      ovf_cnt     += int'(ovf);
      np_perr_cnt += int'(np_perr);
      if (valid && !valid_prev) vrise_cnt++;
      if (valid && ready) begin
        pop_cnt++;
        if (rd_idx >= wr_idx) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no byte at %0t", data, $time);
        end else begin
          check("pop_data", 32'(data), 32'(exp_mem[rd_idx]));
          rd_idx++;
        end
      end
      if (np_valid) begin
        if (np_rd >= np_wr) begin
          checks++;
          errors++;
          $display("FAIL np_pop_unexpected: got 0x%0h expected no byte at %0t", np_data, $time);
        end else begin
          check("np_pop_data", 32'(np_data), 32'(np_mem[np_rd]));
          np_rd++;
        end
      end
    end
    valid_prev = valid;
  end

  // Drive one frame: start, 8 data LSB-first, odd parity, stop.
  // nbits < 8 stops after that many data bits; glitch adds 100 ns low spikes.
  task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad,
                            input int nbits, input bit glitch, input bit pop_at_stop);
    logic [10:0] bits;
    int nedges;
    bits   = {~stop_bad, (~^d) ^ par_flip, d, 1'b0};
    nedges = (nbits >= 8) ? 11 : 1 + nbits;
    for (int i = 0; i < nedges; i++) begin
      ps2_dat = bits[i];
      if (glitch) begin
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b1;
        wait_cyc(HALF - HALF / 2 - 5);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // One-cycle pop lined up with the push of this byte.
        wait_cyc(11);
        ready_req = 1'b1;
        wait_cyc(1);
        ready_req = 1'b0;
        wait_cyc(HALF - 12);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  // Update the reference model from the frame rules, then send the frame.
  task automatic run_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad,
                           input int nbits, input bit glitch, input bit pop_at_stop);
    bit complete;
    complete = (nbits >= 8);
    if (!complete || stop_bad) begin
      exp_ferr++;
    end else begin
      np_mem[np_wr] = d;
      np_wr++;
      if (par_flip) begin
        exp_perr++;
      end else if ((wr_idx - rd_idx) >= DEPTH && !pop_at_stop) begin
        exp_ovf++;
      end else begin
        exp_mem[wr_idx] = d;
        wr_idx++;
      end
    end
    send_frame(d, par_flip, stop_bad, nbits, glitch, pop_at_stop);
  endtask

  task automatic drain(input int cycles);
    ready_req = 1'b1;
    wait_cyc(cycles);
    ready_req = 1'b0;
    wait_cyc(2);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par_flip;
    bit         stop_bad;
    int         nbits;
    bit         glitch;
    int         exp_count;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int b_perr, b_ferr, b_ovf, b_vrise, b_pop, b_np_perr;

    vecs[0] = '{8'h1C, 1'b0, 1'b0, 8, 1'b0, 1, 0, 0};  // good byte
    vecs[1] = '{8'hAA, 1'b1, 1'b0, 8, 1'b0, 0, 1, 0};  // bad parity
    vecs[2] = '{8'h3C, 1'b0, 1'b1, 8, 1'b0, 0, 0, 1};  // stop bit low
    vecs[3] = '{8'hE7, 1'b0, 1'b0, 6, 1'b0, 0, 0, 1};  // timeout after 6 bits
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 8, 1'b0, 1, 0, 0};  // recovery
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8, 1'b0, 1, 0, 0};  // parity bit = 1
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 8, 1'b0, 1, 0, 0};  // parity bit = 1, all ones
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 8, 1'b1, 1, 0, 0};  // clock glitches

    // Reset state.
    wait_cyc(5);
    check("rst_data", 32'(data), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_perr", 32'(perr), 0);
    check("rst_ferr", 32'(ferr), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    wait_cyc(20);
    check("post_rst_valid", 32'(valid), 0);

    // Table-driven single frames, ready low until the check point.
    foreach (vecs[i]) begin
      b_perr = perr_cnt; b_ferr = ferr_cnt; b_ovf = ovf_cnt;
      b_vrise = vrise_cnt; b_np_perr = np_perr_cnt;
      run_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop_bad, vecs[i].nbits, vecs[i].glitch, 1'b0);
      wait_cyc(SETTLE);
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_count != 0));
      check($sformatf("v%0d_valid_rises", i), 32'(vrise_cnt - b_vrise), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_perr", i), 32'(perr_cnt - b_perr), 32'(vecs[i].exp_perr));
      check($sformatf("v%0d_ferr", i), 32'(ferr_cnt - b_ferr), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_ovf", i), 32'(ovf_cnt - b_ovf), 0);
      check($sformatf("v%0d_np_perr", i), 32'(np_perr_cnt - b_np_perr), 32'(vecs[i].exp_perr));
      check($sformatf("v%0d_np_drained", i), 32'(np_rd), 32'(np_wr));
      if (vecs[i].exp_count != 0)
        check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].d));
      ready_req = 1'b1;
      wait_cyc(1);
      ready_req = 1'b0;
      check($sformatf("v%0d_valid_after_pop", i), 32'(valid), 0);
      wait_cyc(3);
      check($sformatf("v%0d_count_after_pop", i), 32'(count), 0);
    end

    // Fill to capacity, then a ninth byte with no pop must overflow.
    for (int i = 1; i <= DEPTH; i++) run_frame(8'(i), 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_cyc(20);
    check("fill_count", 32'(count), DEPTH);
    b_ovf = ovf_cnt;
    run_frame(8'h09, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_cyc(SETTLE);
    check("ovf_pulse", 32'(ovf_cnt - b_ovf), 1);
    check("ovf_count", 32'(count), DEPTH);
    check("ovf_head", 32'(data), 32'h01);
    b_pop = pop_cnt;
    drain(12);
    check("ovf_drain_pops", 32'(pop_cnt - b_pop), DEPTH);
    check("ovf_drain_count", 32'(count), 0);

    // Full again, ninth byte arrives together with a pop: accepted.
    for (int i = 1; i <= DEPTH; i++) run_frame(8'(i), 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_cyc(20);
    b_ovf = ovf_cnt;
    run_frame(8'h09, 1'b0, 1'b0, 8, 1'b0, 1'b1);
    wait_cyc(SETTLE);
    check("full_pop_ovf", 32'(ovf_cnt - b_ovf), 0);
    check("full_pop_count", 32'(count), DEPTH);
    check("full_pop_head", 32'(data), 32'h02);
    b_pop = pop_cnt;
    drain(12);
    check("full_pop_drain_pops", 32'(pop_cnt - b_pop), DEPTH);
    check("full_pop_model_empty", 32'(rd_idx), 32'(wr_idx));

    // Reset mid-frame with a byte buffered: everything discarded.
    run_frame(8'h44, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_cyc(20);
    check("pre_rst_count", 32'(count), 1);
    b_perr = perr_cnt; b_ferr = ferr_cnt;
    send_frame(8'h77, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check("midrst_count", 32'(count), 0);
    check("midrst_valid", 32'(valid), 0);
    check("midrst_data", 32'(data), 0);
    rst = 1'b0;
    wait_cyc(10);
    run_frame(8'h33, 1'b0, 1'b0, 8, 1'b0, 1'b0);
    wait_cyc(SETTLE);
    check("after_rst_count", 32'(count), 1);
    check("after_rst_data", 32'(data), 32'h33);
    check("after_rst_perr", 32'(perr_cnt - b_perr), 0);
    check("after_rst_ferr", 32'(ferr_cnt - b_ferr), 0);
    drain(3);

    // Random frames with random pops.
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                8, 1'b0, 1'b0);
    end
    rand_ready = 1'b0;
    ready_req  = 1'b1;
    wait_cyc(SETTLE);
    ready_req  = 1'b0;
    wait_cyc(2);
    check("rand_model_empty", 32'(rd_idx), 32'(wr_idx));
    check("rand_np_model_empty", 32'(np_rd), 32'(np_wr));
    check("rand_valid", 32'(valid), 0);

    // Totals over the whole run.
    check("total_perr", 32'(perr_cnt), 32'(exp_perr));
    check("total_ferr", 32'(ferr_cnt), 32'(exp_ferr));
    check("total_ovf", 32'(ovf_cnt), 32'(exp_ovf));
    check("total_np_perr", 32'(np_perr_cnt), 32'(exp_perr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
